bram_bank_arb: RTL and testbench
================================

# bram_bank_arb

Two-port burst arbiter and address sequencer in front of one `bram_bank1`/`bram_bank2` instance. It shares the single-address, dp-lane-wide bank between two requesters: requester 0 (host/DMA load) and requester 1 (compute engine). Each granted requester owns the bank for one contiguous read or write burst. The block generates one bank address per cycle and tags the read data returned by the 1-cycle-latency BRAM.

## Interface
Parameters:
- `ADDR_WIDTH`, 11, bank address width (matches attached bank)
- `DATA_WIDTH`, 32, lane width
- `dp`, 512, lanes per bank word
- `LEN_WIDTH`, ADDR_WIDTH+1, burst length width (allows full-bank bursts)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `req0`/`req1` in 1: burst request; must be held until the matching `done`
- `rw0`/`rw1` in 1: 1 = write, 0 = read
- `base0`/`base1` in ADDR_WIDTH: first word address
- `len0`/`len1` in LEN_WIDTH: number of words
- `wdata0`/`wdata1` in dp*DATA_WIDTH: write word for the current beat
- `gnt0`/`gnt1` out 1: requester owns the bank (registered)
- `beat0`/`beat1` out 1: current beat issued this cycle; a write requester advances `wdata` on it
- `done0`/`done1` out 1: one-cycle pulse when the burst retires
- `bank_addr` out ADDR_WIDTH, `bank_we` out 1, `bank_din` out dp*DATA_WIDTH: drive the bank
- `bank_dout` in dp*DATA_WIDTH: bank read data, 1-cycle latency
- `rd_data` out dp*DATA_WIDTH, `rd_valid` out 1, `rd_owner` out 1: tagged read return

## Operation
- FSM states: IDLE, BURST, DRAIN.
- **IDLE:**
  - If any req is high, pick the winner, latch its `base`, `len` and `rw` into `cur_addr`, `remain` and `cur_rw`, set `gnt` for the winner, and go to BURST.
  - If the latched len is 0, go to DRAIN instead. No bank access occurs in that case.
- **Arbitration:** round-robin. A `last` pointer flips to the winner on each grant. When both requests are high, the requester that was not `last` wins. Reset value of `last` is 1, so requester 0 wins the first tie.
- **BURST, each cycle:**
  - `bank_addr = cur_addr`, `bank_we = cur_rw`, `beat` of the owner = 1.
  - `cur_addr` increments modulo 2^ADDR_WIDTH, so a burst wraps past the top of the bank to 0.
  - `remain` decrements; when `remain == 1`, go to DRAIN.
- **bank_din:** combinational mux of the owner's `wdata` (0 when no grant). The requester must present beat k's data during the cycle in which beat k is issued.
- **DRAIN (one cycle):**
  - `bank_we = 0`, `done` of the owner = 1, `gnt` drops at the end of the cycle.
  - Next state is IDLE.
- **Read return:** `rd_valid` is asserted the cycle after each read beat. `rd_owner` is the owner of that beat and `rd_data = bank_dout` (pass-through).
- **Request and input stability:**
  - Deasserting req mid-burst is ignored; the burst always completes.
  - Changes to `base`, `len` or `rw` after the grant are ignored.
- **Reset:** reset during any state aborts the burst without issuing `done`. All outputs clear on the same edge: `gnt`/`beat`/`done`/`bank_we`/`rd_valid`/`rd_owner` = 0, `bank_addr` = 0, `last` = 1.

## Timing
- A req sampled at edge k in IDLE gives `gnt` high and the first beat on the bank in cycle k+1.
- A burst of L ≥ 1 words occupies L BURST cycles plus 1 DRAIN cycle. The next arbitration happens in the IDLE cycle after DRAIN, so back-to-back bursts are separated by one idle cycle.
- Len 0 sequence: IDLE → DRAIN (`done` pulse) → IDLE, 2 cycles, with no bank activity.
- The last read beat's `rd_valid` coincides with the DRAIN cycle.
- Write beat k is committed to the bank at the rising edge that ends beat cycle k.
- `gnt`, `bank_addr`, `bank_we`, `beat`, `done` and `rd_valid` are registered or state-decoded; no requester input reaches them combinationally. `bank_din` and `rd_data` are the only combinational paths.

## Configuration
- `BRAM_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 always wins a tie and the `last` pointer is removed.
- Not defined: round-robin as described above.

## Test plan
- **Write then read, requester 0:** `base=5`, `len=3`, write words A, B, C, then read the same range. Required: `bank_addr` 5, 6, 7 with `bank_we=1`; then `rd_valid` ×3 carrying A, B, C with `rd_owner=0`; one `done0` pulse per burst.
- **Simultaneous requests after reset (both `len=2`):** order is req0, then req1, then req0 again on re-request. Exactly 1 idle cycle separates the bursts. With `BRAM_ARB_FIXED_PRIO_EN` defined, req0 wins every tie.
- **Wrap:** `base=2^ADDR_WIDTH-2`, `len=4` → `bank_addr` sequence top-1, top, 0, 1.
- **Zero-length:** `len=0` → `done` pulse 2 cycles after req, `bank_we` and `rd_valid` stay 0.
- **Reset mid-burst:** `rst_n` low at beat 2 of a `len=8` write. Required: no `done`, all outputs 0 next cycle, and a fresh request afterwards is granted normally starting at its own base.
- **Full-bank burst:** `len=2^ADDR_WIDTH` read from `base=0`. Required: every address issued once, then exactly 2^ADDR_WIDTH `rd_valid` beats.

Source files
------------

// File: rtl/bram_bank_arb.sv
// Two-requester burst arbiter and address sequencer for one single-address BRAM bank.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module bram_bank_arb #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int dp         = 512,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     rw0,
    input  logic                     rw1,
    input  logic [ADDR_WIDTH-1:0]    base0,
    input  logic [ADDR_WIDTH-1:0]    base1,
    input  logic [LEN_WIDTH-1:0]     len0,
    input  logic [LEN_WIDTH-1:0]     len1,
    input  logic [dp*DATA_WIDTH-1:0] wdata0,
    input  logic [dp*DATA_WIDTH-1:0] wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     beat0,
    output logic                     beat1,
    output logic                     done0,
    output logic                     done1,
    output logic [ADDR_WIDTH-1:0]    bank_addr,
    output logic                     bank_we,
    output logic [dp*DATA_WIDTH-1:0] bank_din,
    input  logic [dp*DATA_WIDTH-1:0] bank_dout,
    output logic [dp*DATA_WIDTH-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     rd_owner
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_curRw;
    logic [ADDR_WIDTH-1:0] r_curAddr;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_rdValid;
    logic                  r_rdOwner;

    logic                  w_anyReq;
    logic                  w_pick1;
    logic                  w_selRw;
    logic [ADDR_WIDTH-1:0] w_selBase;
    logic [LEN_WIDTH-1:0]  w_selLen;
    logic                  w_inBurst;
    logic                  w_inDrain;

    assign w_anyReq = req0 | req1;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign w_pick1 = req1 & ~req0;
`else
    logic r_last;
    // On a tie the requester that did not win the previous grant takes the bank.
    assign w_pick1 = req1 & (~req0 | ~r_last);
`endif

    assign w_selRw   = w_pick1 ? rw1   : rw0;
    assign w_selBase = w_pick1 ? base1 : base0;
    assign w_selLen  = w_pick1 ? len1  : len0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_curRw   <= 1'b0;
            r_curAddr <= '0;
            r_remain  <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rdValid <= 1'b0;
            r_rdOwner <= 1'b0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
            r_last    <= 1'b1;
`endif
        end else begin
            // Read data comes back one cycle after its beat, tagged with the beat's owner.
            r_rdValid <= (r_state == BURST) && !r_curRw;
            if ((r_state == BURST) && !r_curRw) begin
                r_rdOwner <= r_owner;
            end
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_owner   <= w_pick1;
                        r_curRw   <= w_selRw;
                        r_curAddr <= w_selBase;
                        r_remain  <= w_selLen;
                        r_gnt0    <= ~w_pick1;
                        r_gnt1    <= w_pick1;
`ifndef BRAM_ARB_FIXED_PRIO_EN
                        r_last    <= w_pick1;
`endif
                        r_state   <= (w_selLen == '0) ? DRAIN : BURST;
                    end
                end
                BURST: begin
                    r_curAddr <= r_curAddr + ADDR_ONE;
                    r_remain  <= r_remain - LEN_ONE;
                    if (r_remain == LEN_ONE) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_inBurst = (r_state == BURST);
    assign w_inDrain = (r_state == DRAIN);

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign beat0     = w_inBurst & ~r_owner;
    assign beat1     = w_inBurst & r_owner;
    assign done0     = w_inDrain & ~r_owner;
    assign done1     = w_inDrain & r_owner;
    assign bank_addr = w_inBurst ? r_curAddr : '0;
    assign bank_we   = w_inBurst & r_curRw;
    assign bank_din  = r_gnt0 ? wdata0 : (r_gnt1 ? wdata1 : '0);
    assign rd_data   = bank_dout;
    assign rd_valid  = r_rdValid;
    assign rd_owner  = r_rdOwner;
endmodule

// File: tb/tb_bram_bank_arb.sv
// Self-checking bench for bram_bank_arb: burst-timeline reference model, BRAM model,
// table-driven arbitration vectors, directed corner cases and randomized traffic.
module tb_bram_bank_arb;
    localparam int AW     = 11;
    localparam int DW     = 32;
    localparam int DP     = 4;
    localparam int LW     = AW + 1;
    localparam int W      = DW * DP;
    localparam int DEPTH  = 1 << AW;
    localparam int BUDGET = 64;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    localparam int TIE_AFTER0 = 0;
`else
    localparam int TIE_AFTER0 = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, rw0, rw1;
    logic [AW-1:0] base0, base1;
    logic [LW-1:0] len0, len1;
    logic [W-1:0]  wdata0, wdata1;
    logic          gnt0, gnt1, beat0, beat1, done0, done1;
    logic [AW-1:0] bank_addr;
    logic          bank_we;
    logic [W-1:0]  bank_din, bank_dout, rd_data;
    logic          rd_valid, rd_owner;

    bram_bank_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .dp(DP), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .base0(base0), .base1(base1), .len0(len0), .len1(len1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .beat0(beat0), .beat1(beat1),
        .done0(done0), .done1(done1),
        .bank_addr(bank_addr), .bank_we(bank_we), .bank_din(bank_din),
        .bank_dout(bank_dout),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_owner(rd_owner)
    );

    always #5 clk = ~clk;

    // Attached bank: one address, write on the edge, read data one cycle later.
    logic [W-1:0] envMem [DEPTH];
    always @(posedge clk) begin
        if (bank_we) envMem[bank_addr] <= bank_din;
        bank_dout <= envMem[bank_addr];
    end

    // One expected record per future cycle; an empty queue means the arbiter is idle.
    typedef struct packed {
        logic          g0, g1, b0, b1, d0, d1, we, rv, ro;
        logic [AW-1:0] addr;
        logic [W-1:0]  din;
        logic [W-1:0]  rdData;
    } cycRec_t;

    typedef struct {
        bit doReset;
        bit go0; bit rw0; int base0; int len0;
        bit go1; bit rw1; int base1; int len1;
        int expOwner;
        int expCycles;
    } vec_t;

    cycRec_t      expQ[$];
    logic [W-1:0] refMem [DEPTH];
    int           modelLast;
    int           checks, errors;
    int           tag0, tag1, bi0, bi1;
    bit           busy0, busy1;
    vec_t         vecs[10];

    function automatic logic [W-1:0] mkWord(int r, int tag, int k);
        return {32'(tag), 32'(r), 32'(k), 32'(tag * 131 + k * 7 + 32'h5A00)};
    endfunction

    task automatic checkValue(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic buildBurst(int o, bit rw, int base, int len, int tag);
        cycRec_t rec;
        for (int k = 0; k < len; k++) begin
            rec      = '0;
            rec.g0   = (o == 0);
            rec.g1   = (o == 1);
            rec.b0   = (o == 0);
            rec.b1   = (o == 1);
            rec.we   = rw;
            rec.addr = AW'((base + k) % DEPTH);
            rec.din  = rw ? mkWord(o, tag, k) : '0;
            rec.rv   = (k > 0) && !rw;
            rec.ro   = (o == 1);
            expQ.push_back(rec);
        end
        rec    = '0;
        rec.g0 = (o == 0);
        rec.g1 = (o == 1);
        rec.d0 = (o == 0);
        rec.d1 = (o == 1);
        rec.rv = (len > 0) && !rw;
        rec.ro = (o == 1);
        expQ.push_back(rec);
    endtask

    // Advance the model across one rising edge using the inputs the DUT sampled there.
    task automatic modelEdge();
        cycRec_t popped, nxt;
        int      w;
        if (expQ.size() > 0) begin
            popped = expQ.pop_front();
            if (popped.we) refMem[popped.addr] = popped.din;
            if ((popped.b0 || popped.b1) && !popped.we && expQ.size() > 0) begin
                nxt        = expQ[0];
                nxt.rdData = refMem[popped.addr];
                expQ[0]    = nxt;
            end
        end else if (rst_n && (req0 || req1)) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            w = req0 ? 0 : 1;
`else
            if (req0 && req1) w = 1 - modelLast;
            else              w = req0 ? 0 : 1;
            modelLast = w;
`endif
            if (w == 0) buildBurst(0, rw0, int'(base0), int'(len0), tag0);
            else        buildBurst(1, rw1, int'(base1), int'(len1), tag1);
        end
        if (!rst_n) begin
            expQ.delete();
            modelLast = 1;
        end
    endtask

    task automatic requesterReact();
        if (beat0) begin wdata0 = mkWord(0, tag0, bi0); bi0++; end
        if (beat1) begin wdata1 = mkWord(1, tag1, bi1); bi1++; end
        if (done0) begin req0 = 1'b0; busy0 = 1'b0; end
        if (done1) begin req1 = 1'b0; busy1 = 1'b0; end
    endtask

    task automatic checkOutput();
        cycRec_t    e;
        bit         ok;
        logic [7:0] actCtl, expCtl;
        e      = (expQ.size() > 0) ? expQ[0] : '0;
        actCtl = {gnt0, gnt1, beat0, beat1, done0, done1, bank_we, rd_valid};
        expCtl = {e.g0, e.g1, e.b0, e.b1, e.d0, e.d1, e.we, e.rv};
        ok     = (actCtl === expCtl);
        if ((e.b0 || e.b1) && bank_addr !== e.addr) ok = 0;
        if (e.we && bank_din !== e.din) ok = 0;
        if (!(e.g0 || e.g1) && bank_din !== '0) ok = 0;
        if (e.rv && (rd_owner !== e.ro || rd_data !== e.rdData)) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL cycle t=%0t ctl act=%b exp=%b addr act=%0d exp=%0d din act=%h exp=%h rdOwner act=%b exp=%b rdData act=%h exp=%h",
                     $time, actCtl, expCtl, bank_addr, e.addr, bank_din, e.din, rd_owner, e.ro, rd_data, e.rdData);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        requesterReact();
        #1;
        checkOutput();
    endtask

    task automatic startReq(int r, bit rw, int base, int len);
        if (r == 0) begin
            tag0++; bi0 = 0; rw0 = rw; base0 = AW'(base); len0 = LW'(len); req0 = 1'b1; busy0 = 1'b1;
        end else begin
            tag1++; bi1 = 0; rw1 = rw; base1 = AW'(base); len1 = LW'(len); req1 = 1'b1; busy1 = 1'b1;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req0  = 1'b0; req1  = 1'b0;
        busy0 = 1'b0; busy1 = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(vec_t v, int idx);
        int n, firstOwner;
        bit seen0, seen1;
        if (v.doReset) doReset();
        if (v.go0) startReq(0, v.rw0, v.base0, v.len0);
        if (v.go1) startReq(1, v.rw1, v.base1, v.len1);
        firstOwner = -1;
        seen0 = !v.go0;
        seen1 = !v.go1;
        n = 0;
        while (!(seen0 && seen1) && n < BUDGET) begin
            tick();
            n++;
            if (firstOwner < 0 && gnt0) firstOwner = 0;
            else if (firstOwner < 0 && gnt1) firstOwner = 1;
            if (done0) seen0 = 1;
            if (done1) seen1 = 1;
        end
        checkValue($sformatf("vec%0d first owner", idx), firstOwner, v.expOwner);
        checkValue($sformatf("vec%0d cycles", idx), n, v.expCycles);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int beats, rvCnt, once, guard, firstAddr;
        bit doneSeen;
        int seenCnt[DEPTH];

        checks = 0; errors = 0; modelLast = 1;
        tag0 = 0; tag1 = 1000; bi0 = 0; bi1 = 0;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        base0 = '0; base1 = '0; len0 = '0; len1 = '0; wdata0 = '0; wdata1 = '0;
        busy0 = 1'b0; busy1 = 1'b0;

        vecs[0] = '{1, 1, 1, 5, 3,      0, 0, 0, 0,      0, 4};
        vecs[1] = '{0, 1, 0, 5, 3,      0, 0, 0, 0,      0, 4};
        vecs[2] = '{1, 1, 0, 5, 2,      1, 0, 6, 2,      0, 7};
        vecs[3] = '{0, 1, 1, 10, 2,     1, 1, 20, 2,     0, 7};
        vecs[4] = '{0, 1, 1, 100, 1,    0, 0, 0, 0,      0, 2};
        vecs[5] = '{0, 1, 0, 100, 1,    1, 0, 20, 1,     TIE_AFTER0, 5};
        vecs[6] = '{0, 0, 0, 0, 0,      1, 1, 50, 0,     1, 1};
        vecs[7] = '{0, 0, 0, 0, 0,      1, 1, 2046, 4,   1, 5};
        vecs[8] = '{0, 1, 0, 2046, 4,   0, 0, 0, 0,      0, 5};
        vecs[9] = '{0, 1, 1, 30, 0,     1, 1, 30, 1,     TIE_AFTER0, 4};

        doReset();
        tick();
        checkValue("reset outputs clear",
                   int'({gnt0, gnt1, beat0, beat1, done0, done1, bank_we, rd_valid, rd_owner, bank_addr}), 0);

        // Full-bank write fills the bank with known data, then a full-bank read returns it.
        startReq(0, 1, 0, DEPTH);
        beats = 0; guard = 0;
        while (busy0 && guard < DEPTH + 20) begin
            tick(); guard++;
            if (beat0) beats++;
        end
        checkValue("fullwr beats", beats, DEPTH);
        tick();
        for (int a = 0; a < DEPTH; a++) seenCnt[a] = 0;
        startReq(0, 0, 0, DEPTH);
        rvCnt = 0; guard = 0;
        while (busy0 && guard < DEPTH + 20) begin
            tick(); guard++;
            if (beat0) seenCnt[bank_addr]++;
            if (rd_valid) rvCnt++;
        end
        once = 0;
        for (int a = 0; a < DEPTH; a++) if (seenCnt[a] == 1) once++;
        checkValue("fullrd rd_valid beats", rvCnt, DEPTH);
        checkValue("fullrd addresses once", once, DEPTH);
        tick();

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

        // Reset during the second beat of an 8-word write.
        startReq(0, 1, 300, 8);
        beats = 0; guard = 0; doneSeen = 0;
        while (beats < 2 && guard < 20) begin
            tick(); guard++;
            if (beat0) beats++;
            if (done0 || done1) doneSeen = 1;
        end
        checkValue("rst reached beat2", beats, 2);
        rst_n = 1'b0;
        tick();
        checkValue("rst outputs clear",
                   int'({gnt0, gnt1, beat0, beat1, done0, done1, bank_we, rd_valid, rd_owner, bank_addr}), 0);
        if (done0 || done1) doneSeen = 1;
        rst_n = 1'b1; req0 = 1'b0; busy0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done0 || done1) doneSeen = 1;
        end
        checkValue("rst no done", int'(doneSeen), 0);
        startReq(1, 0, 40, 2);
        firstAddr = -1; guard = 0;
        while (busy1 && guard < 20) begin
            tick(); guard++;
            if (beat1 && firstAddr < 0) firstAddr = int'(bank_addr);
        end
        checkValue("rst fresh base", firstAddr, 40);
        tick();

        // Random traffic; granted requesters scramble their fields or drop req mid-burst.
        for (int c = 0; c < 3000; c++) begin
            if (!busy0 && $urandom_range(0, 3) == 0)
                startReq(0, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1) : $urandom_range(0, DEPTH - 1),
                         $urandom_range(0, 6));
            if (!busy1 && $urandom_range(0, 3) == 0)
                startReq(1, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1) : $urandom_range(0, DEPTH - 1),
                         $urandom_range(0, 6));
            tick();
            if (gnt0 && busy0 && $urandom_range(0, 2) == 0) begin
                base0 = AW'($urandom); len0 = LW'($urandom); rw0 = 1'($urandom);
                if ($urandom_range(0, 7) == 0) req0 = 1'b0;
            end
            if (gnt1 && busy1 && $urandom_range(0, 2) == 0) begin
                base1 = AW'($urandom); len1 = LW'($urandom); rw1 = 1'($urandom);
                if ($urandom_range(0, 7) == 0) req1 = 1'b0;
            end
        end
        guard = 0;
        while ((busy0 || busy1 || expQ.size() > 0) && guard < 500) begin
            tick(); guard++;
        end
        checkValue("random drain outstanding", int'(busy0 | busy1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
